// File: rtl/sblk_pkg.sv
// -----------------------------------------------------------------------------
// sblk_pkg -- shared definitions for the sub-block activation feed path.
//
// Contents:
//   * default width constants used as parameter defaults by act_feeder
//   * feed_state_e : act_feeder FSM state encoding (IDLE, FEED, DONE)
//   * batch_len_width() : width needed to hold n_tn * n_tp * n_tile without
//     truncation
//   * tile_idx_width()  : width of the tile index (at least 1 bit)
// -----------------------------------------------------------------------------
package sblk_pkg;

    localparam int N_TILE_DEF      = 4;
    localparam int WID_ACT_DEF     = 16;
    localparam int WID_INST_TN_DEF = 4;
    localparam int WID_INST_TP_DEF = 5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FEED = 2'd1,
        ST_DONE = 2'd2
    } feed_state_e;

    // Product of a wid_tn-bit and a wid_tp-bit value fits in wid_tn+wid_tp
    // bits; multiplying by n_tile adds at most $clog2(n_tile) bits.
    function automatic int batch_len_width(input int wid_tn, input int wid_tp,
                                           input int n_tile);
        return wid_tn + wid_tp + $clog2(n_tile);
    endfunction

    function automatic int tile_idx_width(input int n_tile);
        return (n_tile > 1) ? $clog2(n_tile) : 1;
    endfunction

endpackage

// File: rtl/act_skid_buf.sv
// -----------------------------------------------------------------------------
// act_skid_buf -- 2-entry skid buffer on the activation source side.
//
// The upstream ready (in_rdy) comes straight from a flop. The owner supplies
// rdy_en_nxt, its own permission for the *next* cycle, which is combined with
// next-cycle occupancy so the buffer never overflows and never accepts beats
// the owner does not want.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_data/in_vld/in_rdy upstream handshake (in_rdy registered)
//   out_data/out_vld      head of buffer, out_rdy pops it
//   rdy_en_nxt            owner permission for in_rdy in the following cycle
// -----------------------------------------------------------------------------
module act_skid_buf #(
    parameter int WID = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [WID-1:0] in_data,
    input  logic           in_vld,
    output logic           in_rdy,
    output logic [WID-1:0] out_data,
    output logic           out_vld,
    input  logic           out_rdy,
    input  logic           rdy_en_nxt
);

    logic [WID-1:0] mem [2];
    logic           wr_ptr;
    logic           rd_ptr;
    logic [1:0]     count_q;
    logic [1:0]     count_d;
    logic           rdy_q;
    logic           push;
    logic           pop;

    assign push     = in_vld & rdy_q;
    assign pop      = out_vld & out_rdy;
    assign out_vld  = (count_q != 2'd0);
    assign out_data = mem[rd_ptr];
    assign in_rdy   = rdy_q;
    assign count_d  = count_q + 2'(push) - 2'(pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= 1'b0;
            rd_ptr  <= 1'b0;
            count_q <= 2'd0;
            rdy_q   <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples the pre-edge values regardless of statement order.
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            count_q <= count_d;
            rdy_q   <= rdy_en_nxt && (count_d < 2'd2);
        end
    end

    // NOTE: storage is deliberately not reset; occupancy is tracked by
    // count_q, so stale contents are never observed and no reset fan-out
    // is spent on the data array.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= in_data;
    end

endmodule

// File: rtl/act_feeder.sv
// -----------------------------------------------------------------------------
// act_feeder -- feeds one batch of activations per request from a source
// stream into a sub-block activation buffer, tagging each beat with its tile.
//
// Batch length L = n_tn * n_tp * N_TILE (from latched config). Tile index
// advances every n_tn * n_tp beats. One extra request can be queued while a
// batch is running; a further one is dropped and flags err_req_ovf (sticky).
//
// Build option: define ACT_FEEDER_SKID_EN to insert a 2-entry skid buffer
// (act_skid_buf) on the source side with a registered s_act_rdy. Without it,
// s_act_rdy is combinational from the FSM state.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   cfg_load, cfg_n_tn/_tp     config latch pulse and values (IDLE only)
//   act_data_in_req            one-cycle batch request
//   s_act_data/_vld/_rdy       source stream handshake
//   act_data_in_vld, act_data_out, act_tile_idx   registered output beat
//   batch_done                 one-cycle pulse in DONE
//   busy                       FEED or DONE
//   err_req_ovf                sticky request-overflow flag
// -----------------------------------------------------------------------------
module act_feeder
    import sblk_pkg::*;
#(
    parameter int N_TILE      = N_TILE_DEF,
    parameter int WID_ACT     = WID_ACT_DEF,
    parameter int WID_INST_TN = WID_INST_TN_DEF,
    parameter int WID_INST_TP = WID_INST_TP_DEF
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                cfg_load,
    input  logic [WID_INST_TN-1:0]              cfg_n_tn,
    input  logic [WID_INST_TP-1:0]              cfg_n_tp,
    input  logic                                act_data_in_req,
    input  logic [WID_ACT-1:0]                  s_act_data,
    input  logic                                s_act_vld,
    output logic                                s_act_rdy,
    output logic                                act_data_in_vld,
    output logic [WID_ACT-1:0]                  act_data_out,
    output logic [tile_idx_width(N_TILE)-1:0]   act_tile_idx,
    output logic                                batch_done,
    output logic                                busy,
    output logic                                err_req_ovf
);

    localparam int TILE_W = tile_idx_width(N_TILE);
    localparam int PER_W  = WID_INST_TN + WID_INST_TP;
    localparam int LEN_W  = batch_len_width(WID_INST_TN, WID_INST_TP, N_TILE);

    feed_state_e            state_q;
    feed_state_e            state_d;
    logic [WID_INST_TN-1:0] n_tn_q;
    logic [WID_INST_TP-1:0] n_tp_q;
    logic [PER_W-1:0]       per_tile;
    logic [LEN_W-1:0]       batch_len;
    logic                   len_zero;
    logic [LEN_W-1:0]       beat_cnt_q;
    logic [PER_W-1:0]       sub_cnt_q;
    logic [TILE_W-1:0]      tile_q;
    logic                   pend_q;
    logic                   err_q;
    logic                   start_batch;
    logic                   feed_rdy;
    logic                   accept;
    logic [WID_ACT-1:0]     src_data;
    logic                   src_vld;
    logic                   vld_q;
    logic [WID_ACT-1:0]     data_q;
    logic [TILE_W-1:0]      tile_out_q;

    assign per_tile  = PER_W'(n_tn_q) * PER_W'(n_tp_q);
    assign batch_len = LEN_W'(per_tile) * LEN_W'(N_TILE);
    assign len_zero  = (batch_len == '0);

    // The feed stage only consumes while in FEED; leaving FEED on the last
    // accepted beat is what closes ready once L beats are in.
    assign feed_rdy = (state_q == ST_FEED);
    assign accept   = src_vld & feed_rdy;

`ifdef ACT_FEEDER_SKID_EN
    logic [LEN_W-1:0] in_cnt_q;
    logic [LEN_W-1:0] in_cnt_d;
    logic             in_push;
    logic             rdy_en_nxt;

    assign in_push  = s_act_vld & s_act_rdy;
    assign in_cnt_d = start_batch ? '0 : (in_cnt_q + LEN_W'(in_push));
    // Source-side count caps pushes at L per batch so the buffer only ever
    // holds beats of the running batch.
    assign rdy_en_nxt = (state_d == ST_FEED) && (in_cnt_d < batch_len);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) in_cnt_q <= '0;
        else        in_cnt_q <= in_cnt_d;
    end

    act_skid_buf #(.WID(WID_ACT)) u_skid (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (s_act_data),
        .in_vld     (s_act_vld),
        .in_rdy     (s_act_rdy),
        .out_data   (src_data),
        .out_vld    (src_vld),
        .out_rdy    (feed_rdy),
        .rdy_en_nxt (rdy_en_nxt)
    );
`else
    assign src_data  = s_act_data;
    assign src_vld   = s_act_vld;
    assign s_act_rdy = feed_rdy;
`endif

    // Next-state logic. A request arriving in DONE with nothing pending is
    // treated exactly like a pending one.
    always_comb begin
        // NOTE: defaults first so every path assigns every output; this is
        // what keeps the combinational block free of inferred latches.
        state_d     = state_q;
        start_batch = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (act_data_in_req || pend_q) begin
                    state_d     = len_zero ? ST_DONE : ST_FEED;
                    start_batch = !len_zero;
                end
            end
            ST_FEED: begin
                if (accept && (beat_cnt_q == batch_len - LEN_W'(1)))
                    state_d = ST_DONE;
            end
            ST_DONE: begin
                if (pend_q || act_data_in_req) begin
                    state_d     = len_zero ? ST_DONE : ST_FEED;
                    start_batch = !len_zero;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            n_tn_q     <= '0;
            n_tp_q     <= '0;
            pend_q     <= 1'b0;
            err_q      <= 1'b0;
            beat_cnt_q <= '0;
            sub_cnt_q  <= '0;
            tile_q     <= '0;
            vld_q      <= 1'b0;
            data_q     <= '0;
            tile_out_q <= '0;
        end else begin
            state_q <= state_d;

            if (state_q == ST_IDLE && cfg_load) begin
                n_tn_q <= cfg_n_tn;
                n_tp_q <= cfg_n_tp;
            end

            // Pending is only raised in FEED; DONE always consumes it.
            if (state_q == ST_FEED && act_data_in_req && !pend_q)
                pend_q <= 1'b1;
            else if (state_q != ST_FEED)
                pend_q <= 1'b0;

            if (act_data_in_req && pend_q && state_q != ST_IDLE)
                err_q <= 1'b1;

            if (start_batch) begin
                beat_cnt_q <= '0;
                sub_cnt_q  <= '0;
                tile_q     <= '0;
            end else if (accept) begin
                beat_cnt_q <= beat_cnt_q + LEN_W'(1);
                if (sub_cnt_q == per_tile - PER_W'(1)) begin
                    sub_cnt_q <= '0;
                    tile_q    <= tile_q + TILE_W'(1);
                end else begin
                    sub_cnt_q <= sub_cnt_q + PER_W'(1);
                end
            end

            vld_q <= accept;
            if (accept) begin
                data_q     <= src_data;
                tile_out_q <= tile_q;
            end
        end
    end

    assign act_data_in_vld = vld_q;
    assign act_data_out    = data_q;
    assign act_tile_idx    = tile_out_q;
    assign batch_done      = (state_q == ST_DONE);
    assign busy            = (state_q != ST_IDLE);
    assign err_req_ovf     = err_q;

endmodule

// File: tb/tb_act_feeder.sv
// -----------------------------------------------------------------------------
// tb_act_feeder -- self-checking bench for act_feeder (N_TILE = 4).
// Reference model: a batch is tn*tp*4 beats; beat i of a batch carries the
// i-th accepted source word with tile index i / (tn*tp).
// -----------------------------------------------------------------------------
module tb_act_feeder;

    localparam int N_TILE  = 4;
    localparam int WID_ACT = 16;
    localparam int WTN     = 4;
    localparam int WTP     = 5;
    localparam int TW      = 2;

    logic               clk = 1'b0;
    logic               rst_n = 1'b1;
    logic               cfg_load = 1'b0;
    logic [WTN-1:0]     cfg_n_tn = '0;
    logic [WTP-1:0]     cfg_n_tp = '0;
    logic               act_data_in_req = 1'b0;
    logic [WID_ACT-1:0] s_act_data = '0;
    logic               s_act_vld = 1'b0;
    logic               s_act_rdy;
    logic               act_data_in_vld;
    logic [WID_ACT-1:0] act_data_out;
    logic [TW-1:0]      act_tile_idx;
    logic               batch_done;
    logic               busy;
    logic               err_req_ovf;

    act_feeder #(
        .N_TILE(N_TILE), .WID_ACT(WID_ACT), .WID_INST_TN(WTN), .WID_INST_TP(WTP)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .cfg_load        (cfg_load),
        .cfg_n_tn        (cfg_n_tn),
        .cfg_n_tp        (cfg_n_tp),
        .act_data_in_req (act_data_in_req),
        .s_act_data      (s_act_data),
        .s_act_vld       (s_act_vld),
        .s_act_rdy       (s_act_rdy),
        .act_data_in_vld (act_data_in_vld),
        .act_data_out    (act_data_out),
        .act_tile_idx    (act_tile_idx),
        .batch_done      (batch_done),
        .busy            (busy),
        .err_req_ovf     (err_req_ovf)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Observation state, written only by the monitor / clear task.
    logic [WID_ACT-1:0] acc_q[$];
    logic [WID_ACT-1:0] out_d[$];
    int                 out_t[$];
    int                 out_c[$];
    int                 done_c[$];
    int                 done_cnt = 0;
    int                 cyc = 0;
    bit                 rdy_seen = 0;
    bit                 busy_gap = 0;
    bit                 src_run = 0;

    task automatic clear_mon();
        acc_q.delete(); out_d.delete(); out_t.delete(); out_c.delete(); done_c.delete();
        done_cnt = 0; rdy_seen = 0; busy_gap = 0;
    endtask

    task automatic monitor();
        bit                 hs;
        bit                 prev_hs = 0;
        logic [WID_ACT-1:0] prev_data = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_hs = 0;
            end else begin
                cyc++;
                hs = s_act_vld && s_act_rdy;
`ifndef ACT_FEEDER_SKID_EN
                n_checks++;
                if (act_data_in_vld !== prev_hs || (prev_hs && act_data_out !== prev_data)) begin
                    n_errors++;
                    $display("FAIL latency @%0t: vld=%b data=%h, required vld=%b data=%h",
                             $time, act_data_in_vld, act_data_out, prev_hs, prev_data);
                end
`endif
                if (busy !== 1'b1) begin
                    n_checks++;
                    if (s_act_rdy !== 1'b0) begin
                        n_errors++;
                        $display("FAIL rdy_when_idle @%0t: s_act_rdy=%b, required 0", $time, s_act_rdy);
                    end
                end
                if (s_act_rdy === 1'b1) rdy_seen = 1;
                if (hs) acc_q.push_back(s_act_data);
                if (act_data_in_vld === 1'b1) begin
                    out_d.push_back(act_data_out);
                    out_t.push_back(int'(act_tile_idx));
                    out_c.push_back(cyc);
                end
                if (done_cnt == 1 && busy !== 1'b1) busy_gap = 1;
                if (batch_done === 1'b1) begin
                    done_cnt++;
                    done_c.push_back(cyc);
                end
                prev_hs   = hs;
                prev_data = s_act_data;
            end
        end
    endtask

    // mode 0: vld always high, 1: toggles 1/0, 2: random
    task automatic drive_src(input int mode);
        bit hs;
        s_act_data = WID_ACT'($urandom);
        s_act_vld  = 1'b1;
        while (src_run) begin
            @(negedge clk);
            hs = s_act_vld && s_act_rdy;
            @(posedge clk);
            #1;
            if (hs || !s_act_vld) s_act_data = WID_ACT'($urandom);
            case (mode)
                0:       s_act_vld = 1'b1;
                1:       s_act_vld = !s_act_vld;
                default: s_act_vld = 1'($urandom_range(0, 1));
            endcase
        end
        s_act_vld = 1'b0;
    endtask

    task automatic do_cfg(input int tn, input int tp);
        @(posedge clk); #1;
        cfg_load = 1'b1; cfg_n_tn = WTN'(tn); cfg_n_tp = WTP'(tp);
        @(posedge clk); #1;
        cfg_load = 1'b0;
    endtask

    task automatic pulse_req();
        act_data_in_req = 1'b1;
        @(posedge clk); #1;
        act_data_in_req = 1'b0;
    endtask

    task automatic start_batch(input int mode);
        @(posedge clk); #1;
        clear_mon();
        src_run = 1;
        fork
            drive_src(mode);
        join_none
        pulse_req();
    endtask

    task automatic stop_src();
        src_run = 0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic finish_batch(input string name, input int tn, input int tp, input int nb);
        int l = tn * tp * N_TILE;
        int p = tn * tp;
        bit timed_out = 1;
        int n;
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk); #2;
            if (done_cnt >= nb && busy === 1'b0) begin
                timed_out = 0;
                break;
            end
        end
        stop_src();
        n_checks++;
        if (timed_out) begin
            n_errors++;
            $display("FAIL %s timeout: done_cnt=%0d busy=%b, required %0d and 0", name, done_cnt, busy, nb);
        end
        n_checks++;
        if (done_cnt != nb) begin
            n_errors++;
            $display("FAIL %s done_count: got %0d, required %0d", name, done_cnt, nb);
        end
        n_checks++;
        if (out_d.size() != l * nb) begin
            n_errors++;
            $display("FAIL %s beat_count: got %0d, required %0d", name, out_d.size(), l * nb);
        end
        n_checks++;
        if (acc_q.size() != l * nb) begin
            n_errors++;
            $display("FAIL %s accept_count: got %0d, required %0d", name, acc_q.size(), l * nb);
        end
        n = (out_d.size() < acc_q.size()) ? out_d.size() : acc_q.size();
        if (l > 0) begin
            for (int i = 0; i < n; i++) begin
                n_checks++;
                if (out_d[i] !== acc_q[i] || out_t[i] != (i % l) / p) begin
                    n_errors++;
                    $display("FAIL %s beat%0d: data=%h tile=%0d, required data=%h tile=%0d",
                             name, i, out_d[i], out_t[i], acc_q[i], (i % l) / p);
                end
            end
            for (int b = 0; b < done_c.size(); b++) begin
                if ((b + 1) * l - 1 < out_c.size()) begin
                    n_checks++;
                    if (done_c[b] < out_c[(b + 1) * l - 1]) begin
                        n_errors++;
                        $display("FAIL %s done_order%0d: done cycle %0d, required >= %0d",
                                 name, b, done_c[b], out_c[(b + 1) * l - 1]);
                    end
                end
            end
        end
    endtask

    task automatic check_all_zero(input string name);
        n_checks++;
        if ({s_act_rdy, act_data_in_vld, act_data_out, act_tile_idx, batch_done, busy, err_req_ovf} !== '0) begin
            n_errors++;
            $display("FAIL %s outputs: rdy=%b vld=%b data=%h tile=%0d done=%b busy=%b err=%b, required all 0",
                     name, s_act_rdy, act_data_in_vld, act_data_out, act_tile_idx, batch_done, busy, err_req_ovf);
        end
    endtask

    task automatic test_reset();
        #3 rst_n = 1'b0;
        #1 check_all_zero("reset_asserted");
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (2) @(negedge clk);
        #2 check_all_zero("reset_released");
    endtask

    task automatic test_basic();
        do_cfg(2, 3);
        start_batch(0);
        finish_batch("basic", 2, 3, 1);
    endtask

    task automatic test_toggle();
        start_batch(1);
        finish_batch("toggle", 2, 3, 1);
    endtask

    task automatic test_zero();
        do_cfg(0, 3);
        start_batch(0);
        @(negedge clk); #1;
        n_checks++;
        if (batch_done !== 1'b1) begin
            n_errors++;
            $display("FAIL zero_done_timing: batch_done=%b, required 1", batch_done);
        end
        finish_batch("zero", 0, 3, 1);
        n_checks++;
        if (rdy_seen) begin
            n_errors++;
            $display("FAIL zero_rdy: s_act_rdy seen high, required never");
        end
    endtask

    task automatic test_cfg_ignore();
        do_cfg(2, 3);
        start_batch(1);
        repeat (4) @(posedge clk);
        #1 cfg_load = 1'b1; cfg_n_tn = WTN'(2); cfg_n_tp = WTP'(7);
        @(posedge clk); #1 cfg_load = 1'b0;
        finish_batch("cfg_ignore_cur", 2, 3, 1);
        start_batch(0);
        finish_batch("cfg_ignore_next", 2, 3, 1);
    endtask

    task automatic test_random();
        int tn;
        int tp;
        for (int k = 0; k < 4; k++) begin
            tn = int'($urandom_range(1, 3));
            tp = int'($urandom_range(1, 3));
            do_cfg(tn, tp);
            start_batch(2);
            finish_batch($sformatf("random%0d", k), tn, tp, 1);
        end
    endtask

    task automatic test_req_in_done();
        bit found = 0;
        do_cfg(1, 1);
        start_batch(0);
        for (int c = 0; c < 200; c++) begin
            @(negedge clk); #1;
            if (batch_done === 1'b1) begin
                found = 1;
                break;
            end
        end
        n_checks++;
        if (!found) begin
            n_errors++;
            $display("FAIL req_in_done_wait: batch_done never seen, required within 200 cycles");
        end
        act_data_in_req = 1'b1;
        @(posedge clk); #1 act_data_in_req = 1'b0;
        finish_batch("req_in_done", 1, 1, 2);
        n_checks++;
        if (busy_gap || err_req_ovf !== 1'b0) begin
            n_errors++;
            $display("FAIL req_in_done_flags: gap=%b err=%b, required 0 and 0", busy_gap, err_req_ovf);
        end
    endtask

    task automatic test_back_to_back();
        start_batch(0);
        pulse_req();
        pulse_req();
        finish_batch("back_to_back", 1, 1, 2);
        n_checks++;
        if (busy_gap) begin
            n_errors++;
            $display("FAIL back_to_back_gap: busy dropped between batches, required continuous");
        end
        n_checks++;
        if (err_req_ovf !== 1'b1) begin
            n_errors++;
            $display("FAIL back_to_back_err: err_req_ovf=%b, required 1", err_req_ovf);
        end
    endtask

    task automatic test_reset_mid();
        bit found = 0;
        do_cfg(2, 3);
        start_batch(0);
        for (int c = 0; c < 200; c++) begin
            @(negedge clk); #2;
            if (out_d.size() >= 10) begin
                found = 1;
                break;
            end
        end
        n_checks++;
        if (!found) begin
            n_errors++;
            $display("FAIL reset_mid_wait: beats=%0d, required 10", out_d.size());
        end
        rst_n = 1'b0;
        #1 check_all_zero("reset_mid");
        stop_src();
        #2 rst_n = 1'b1;
        clear_mon();
        repeat (5) @(posedge clk);
        #1;
        n_checks++;
        if (done_cnt != 0 || out_d.size() != 0 || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_mid_quiet: done=%0d beats=%0d busy=%b, required 0 0 0", done_cnt, out_d.size(), busy);
        end
        // Config was cleared by reset: a request now is an empty batch.
        start_batch(0);
        finish_batch("reset_cfg_cleared", 0, 0, 1);
        do_cfg(2, 3);
        start_batch(0);
        finish_batch("reset_fresh", 2, 3, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        fork
            monitor();
        join_none
        test_reset();
        test_basic();
        test_toggle();
        test_zero();
        test_cfg_ignore();
        test_random();
        test_req_in_done();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/act_feeder.md
ACT_FEEDER -- requirements
Module: act_feeder

Interface
REQ-001 Parameter N_TILE, default 4, number of spatial tiles fed per batch.
REQ-002 Parameter WID_ACT, default 16, activation word width.
REQ-003 Parameter WID_INST_TN, default 4, width of cfg_n_tn; WID_INST_TP, default 5, width of cfg_n_tp.
REQ-004 clk  input  1  single clock; all state on posedge clk.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 cfg_load  input  1  one-cycle pulse; latches cfg_n_tn/cfg_n_tp.
REQ-007 cfg_n_tn  input  WID_INST_TN  temporal N-trip count; cfg_n_tp  input  WID_INST_TP  temporal P-trip count.
REQ-008 act_data_in_req  input  1  one-cycle batch request from the sub-block controller.
REQ-009 s_act_data  input  WID_ACT  source stream data; s_act_vld  input  1; s_act_rdy  output  1.
REQ-010 act_data_in_vld  output  1  one beat to sub-block act buffer; act_data_out  output  WID_ACT.
REQ-011 act_tile_idx  output  $clog2(N_TILE)  tile index of current output beat.
REQ-012 batch_done  output  1  one-cycle pulse at batch end; busy  output  1; err_req_ovf  output  1 sticky.

Function
REQ-013 Batch length L = n_tn*n_tp*N_TILE, computed from latched values at WID_INST_TN+WID_INST_TP+$clog2(N_TILE) bits, no truncation.
REQ-014 cfg_load is honoured only in IDLE; ignored otherwise, latched config unchanged.
REQ-015 FSM states IDLE, FEED, DONE; busy=1 in FEED and DONE.
REQ-016 IDLE->FEED on act_data_in_req (or pending request) when L!=0; when L==0, IDLE->DONE directly, no beats emitted.
REQ-017 In FEED a beat is accepted when s_act_vld & s_act_rdy; s_act_rdy=0 outside FEED and once L beats accepted.
REQ-018 Each accepted beat appears on act_data_in_vld/act_data_out exactly one cycle later, in order, no drops, no duplicates.
REQ-019 Tile index starts 0, increments after every n_tn*n_tp beats, reaches N_TILE-1 on the final beat.
REQ-020 Acceptance of beat L-1 moves FEED->DONE; DONE lasts one cycle with batch_done=1, coincident with or after last act_data_in_vld.
REQ-021 act_data_in_req during FEED/DONE sets a 1-deep pending flag; DONE->FEED if pending (flag cleared) else DONE->IDLE.
REQ-022 act_data_in_req while pending already set is dropped and sets err_req_ovf, cleared only by reset.
REQ-023 act_data_in_req in same cycle as DONE with no pending: counts as pending, next state FEED.

Reset
REQ-024 On rst_n low, asynchronously: state IDLE, counters, pending, latched config and err_req_ovf to 0; all outputs 0.
REQ-025 Reset mid-FEED abandons batch; no batch_done after release; next batch restarts at beat 0, tile 0.

Configuration
REQ-026 Macro ACT_FEEDER_SKID_EN defined: 2-entry skid buffer on source side, s_act_rdy driven from a register, output latency stays one cycle after buffer accept.
REQ-027 ACT_FEEDER_SKID_EN undefined: no buffer, s_act_rdy combinational from state/count; beat ordering and counts identical.

Structure
REQ-028 Shared package sblk_pkg holds the FSM state enum, default width constants and the batch-length width function.
REQ-029 Skid buffer is sub-module act_skid_buf, instantiated only under ACT_FEEDER_SKID_EN.

Verification (N_TILE=4)
REQ-030 cfg n_tn=2,n_tp=3, one req, s_act_vld constant -> 24 vld beats, tile_idx 0..3 changing every 6 beats, one batch_done.
REQ-031 Same cfg, s_act_vld toggled 1/0 -> 24 beats, data order preserved, batch_done once after beat 24.
REQ-032 n_tn=0 -> req yields batch_done one cycle later, zero vld beats, s_act_rdy stays 0.
REQ-033 Two reqs during FEED (n_tn=1,n_tp=1) -> second batch of 4 beats runs back-to-back, third req sets err_req_ovf=1.
REQ-034 rst_n asserted after beat 10 of 24 -> all outputs 0 immediately, next req produces fresh 24 beats from tile 0.
REQ-035 cfg_load n_tp=7 during FEED -> ignored; current and following batch use n_tp=3.
